// File: rtl/axis_frame_gen.sv
// AXI-Stream traffic source: emits runs of frames with gaps, backpressure and abort.
// Define AXIS_FRAME_GEN_LFSR_EN to take payload from a 16-bit LFSR instead of seed + beat index.
module axis_frame_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic [CNT_WIDTH-1:0]  frame_count,
  input  logic [GAP_WIDTH-1:0]  gap_len,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  frames_sent
);
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  state_t                state_r;
  logic [LEN_WIDTH-1:0]  len_r, beat_r;
  logic [CNT_WIDTH-1:0]  left_r, sent_r;
  logic [GAP_WIDTH-1:0]  gap_len_r, gap_cnt_r;
  logic [DATA_WIDTH-1:0] seed_r, tdata_r;
  logic                  tvalid_r, tlast_r, tuser_r, busy_r, done_r, abort_pend_r;

  logic                  start_ok_s, xfer_s, abort_eff_s, stop_s, last_nxt_s, first_last_s;
  logic                  load0_s, step_s;
  logic [LEN_WIDTH-1:0]  beat_nxt_s, len_src_s;
  logic [DATA_WIDTH-1:0] seed_src_s, data0_s, data_nxt_s;

  assign start_ok_s   = start & (frame_len != LEN_WIDTH'(0)) & (frame_count != CNT_WIDTH'(0));
  assign xfer_s       = tvalid_r & output_axis_tready;
  assign abort_eff_s  = abort | abort_pend_r;
  assign stop_s       = abort_eff_s | (left_r == CNT_WIDTH'(1));
  assign beat_nxt_s   = beat_r + LEN_WIDTH'(1);
  assign last_nxt_s   = (beat_nxt_s == (len_r - LEN_WIDTH'(1)));
  // In IDLE the run parameters are not latched yet, so beat 0 comes straight from the inputs.
  assign seed_src_s   = (state_r == IDLE) ? seed : seed_r;
  assign len_src_s    = (state_r == IDLE) ? frame_len : len_r;
  assign first_last_s = (len_src_s == LEN_WIDTH'(1));

`ifdef AXIS_FRAME_GEN_LFSR_EN
  logic [15:0] lfsr_r, lfsr0_s;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] lfsr_init(input logic [DATA_WIDTH-1:0] sd);
    logic [15:0] v;
    v = 16'({sd, ~sd});
    if (v == 16'h0000) v = 16'h0001;
    return v;
  endfunction

  assign lfsr0_s    = lfsr_init(seed_src_s);
  assign data0_s    = DATA_WIDTH'(lfsr0_s);
  assign data_nxt_s = DATA_WIDTH'(lfsr_step(lfsr_r));

  // LFSR state of the presented beat: reseeded per frame, advanced per transferred beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_r <= 16'h0000;
    end else if (load0_s) begin
      lfsr_r <= lfsr0_s;
    end else if (step_s) begin
      lfsr_r <= lfsr_step(lfsr_r);
    end else begin
      lfsr_r <= lfsr_r;
    end
  end
`else
  assign data0_s    = seed_src_s;
  assign data_nxt_s = tdata_r + DATA_WIDTH'(1);
`endif

  // Decide whether the beat registers load beat 0 of a frame or advance to the next beat.
  always_comb begin
    load0_s = 1'b0;
    step_s  = 1'b0;
    case (state_r)
      IDLE: load0_s = start_ok_s;
      SEND: begin
        if (xfer_s && tlast_r) begin
          load0_s = ~stop_s & (gap_len_r == GAP_WIDTH'(0));
        end else begin
          step_s = xfer_s;
        end
      end
      GAP:     load0_s = ~abort & (gap_cnt_r == GAP_WIDTH'(1));
      default: load0_s = 1'b0;
    endcase
  end

  // Run control and registered stream outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      len_r        <= LEN_WIDTH'(0);
      beat_r       <= LEN_WIDTH'(0);
      left_r       <= CNT_WIDTH'(0);
      sent_r       <= CNT_WIDTH'(0);
      gap_len_r    <= GAP_WIDTH'(0);
      gap_cnt_r    <= GAP_WIDTH'(0);
      seed_r       <= DATA_WIDTH'(0);
      tdata_r      <= DATA_WIDTH'(0);
      tvalid_r     <= 1'b0;
      tlast_r      <= 1'b0;
      tuser_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      abort_pend_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (load0_s) begin
        state_r  <= SEND;
        busy_r   <= 1'b1;
        tvalid_r <= 1'b1;
        tdata_r  <= data0_s;
        tlast_r  <= first_last_s;
        tuser_r  <= 1'b0;
        beat_r   <= LEN_WIDTH'(0);
      end else if (step_s) begin
        // A pending or concurrent abort truncates the frame at the beat loaded now.
        tdata_r      <= data_nxt_s;
        beat_r       <= beat_nxt_s;
        tlast_r      <= last_nxt_s | abort_eff_s;
        tuser_r      <= abort_eff_s;
        abort_pend_r <= abort_eff_s;
      end else begin
        tdata_r <= tdata_r;
      end
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            len_r        <= frame_len;
            left_r       <= frame_count;
            gap_len_r    <= gap_len;
            seed_r       <= seed;
            abort_pend_r <= 1'b0;
          end
        end
        SEND: begin
          if (xfer_s && tlast_r) begin
            sent_r <= sent_r + CNT_WIDTH'(1);
            left_r <= left_r - CNT_WIDTH'(1);
            if (stop_s) begin
              state_r      <= IDLE;
              tvalid_r     <= 1'b0;
              tlast_r      <= 1'b0;
              tuser_r      <= 1'b0;
              busy_r       <= 1'b0;
              done_r       <= 1'b1;
              abort_pend_r <= 1'b0;
            end else if (gap_len_r != GAP_WIDTH'(0)) begin
              state_r   <= GAP;
              tvalid_r  <= 1'b0;
              tlast_r   <= 1'b0;
              gap_cnt_r <= gap_len_r;
            end
          end else if (abort) begin
            abort_pend_r <= 1'b1;
          end
        end
        GAP: begin
          if (abort) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b1;
            abort_pend_r <= 1'b0;
          end else if (gap_cnt_r != GAP_WIDTH'(1)) begin
            gap_cnt_r <= gap_cnt_r - GAP_WIDTH'(1);
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign output_axis_tdata  = tdata_r;
  assign output_axis_tvalid = tvalid_r;
  assign output_axis_tlast  = tlast_r;
  assign output_axis_tuser  = tuser_r;
  assign busy               = busy_r;
  assign done               = done_r;
  assign frames_sent        = sent_r;
endmodule

// File: tb/tb_axis_frame_gen.sv
// Randomised self-checking bench for axis_frame_gen against a beat/frame-index reference model.
module tb_axis_frame_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, tready;
  logic [15:0] frame_len, frame_count;
  logic [7:0]  gap_len, seed;
  logic [7:0]  tdata;
  logic        tvalid, tlast, tuser, busy, done;
  logic [15:0] frames_sent;

  int checks = 0;
  int errors = 0;

  axis_frame_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .frame_len(frame_len), .frame_count(frame_count), .gap_len(gap_len), .seed(seed),
    .output_axis_tdata(tdata), .output_axis_tvalid(tvalid), .output_axis_tready(tready),
    .output_axis_tlast(tlast), .output_axis_tuser(tuser),
    .busy(busy), .done(done), .frames_sent(frames_sent)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Payload of beat i in a frame, recomputed from scratch.
  function automatic logic [7:0] pay(input logic [7:0] sd, input int i);
`ifdef AXIS_FRAME_GEN_LFSR_EN
    logic [15:0] s;
    s = {sd, ~sd};
    if (s == 16'h0000) s = 16'h0001;
    for (int k = 0; k < i; k++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    return s[7:0];
`else
    return sd + 8'(i);
`endif
  endfunction

  // Reference model: phase 0 idle, 1 sending, 2 gap; frame index m_f, beat index m_i.
  int         m_on = 0, m_phase = 0, m_len = 0, m_cnt = 0, m_gap = 0;
  int         m_f = 0, m_i = 0, m_gapleft = 0, m_sent = 0;
  logic [7:0] m_seed = 8'h00;
  bit         m_pend = 1'b0, m_trunc = 1'b0, m_done = 1'b0;

  task automatic finish_run();
    m_phase = 0; m_done = 1'b1; m_pend = 1'b0; m_trunc = 1'b0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_on = 1; m_phase = 0; m_pend = 1'b0; m_trunc = 1'b0; m_done = 1'b0;
      m_sent = 0; m_i = 0; m_f = 0;
    end else begin
      m_done = 1'b0;
      case (m_phase)
        0: if (start && frame_len != 16'd0 && frame_count != 16'd0) begin
             m_len = int'(frame_len); m_cnt = int'(frame_count); m_gap = int'(gap_len);
             m_seed = seed; m_f = 0; m_i = 0; m_trunc = 1'b0; m_pend = 1'b0; m_phase = 1;
           end
        1: if (tready) begin
             if (m_i == m_len - 1 || m_trunc) begin
               m_sent++;
               if (m_pend || abort || m_f == m_cnt - 1) finish_run();
               else begin
                 m_f++; m_i = 0; m_trunc = 1'b0;
                 if (m_gap != 0) begin m_phase = 2; m_gapleft = m_gap; end
               end
             end else begin
               m_i++;
               m_trunc = m_pend || abort;
               m_pend = m_trunc;
             end
           end else if (abort) m_pend = 1'b1;
        2: if (abort) finish_run();
           else begin
             m_gapleft--;
             if (m_gapleft == 0) begin m_phase = 1; m_i = 0; m_trunc = 1'b0; end
           end
        default: m_phase = 0;
      endcase
    end
  endtask

  // Single compare process: check DUT against the model, then advance the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_on != 0) begin
        chk("tvalid", 32'(tvalid), 32'(m_phase == 1));
        if (m_phase == 1) begin
          chk("tdata", 32'(tdata), 32'(pay(m_seed, m_i)));
          chk("tlast", 32'(tlast), 32'((m_i == m_len - 1) || m_trunc));
          chk("tuser", 32'(tuser), 32'(m_trunc));
        end
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("done", 32'(done), 32'(m_done));
        chk("frames_sent", 32'(frames_sent), 32'(m_sent & 32'hFFFF));
      end
      model_step();
    end
  end

  typedef struct packed { logic [7:0] d; logic l; logic u; } beat_t;
  beat_t acc_q[$];
  int    done_cnt = 0;

  // Record accepted beats and done pulses for the literal checks.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && tvalid && tready) acc_q.push_back({tdata, tlast, tuser});
      if (rst_n && done) done_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input int len, input int cnt, input int gap, input logic [7:0] sd);
    frame_len = 16'(len); frame_count = 16'(cnt); gap_len = 8'(gap); seed = sd;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin tick(); n++; end
    chk("run_ends", 32'(busy), 32'd0);
  endtask

  int nl;
`ifdef AXIS_FRAME_GEN_LFSR_EN
  logic [7:0] gold [4] = '{8'hFE, 8'hFC, 8'hF8, 8'hF1};
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tready = 1'b1;
    frame_len = 16'd0; frame_count = 16'd0; gap_len = 8'd0; seed = 8'd0;
    repeat (3) tick();
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tdata", 32'(tdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sent", 32'(frames_sent), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single 4-beat frame, seed 0x10.
    acc_q.delete(); done_cnt = 0;
    chk("t1_pre_valid", 32'(tvalid), 32'd0);
    run_start(4, 1, 0, 8'h10);
    chk("t1_latency_valid", 32'(tvalid), 32'd1);
    wait_idle(50); repeat (2) tick();
    chk("t1_beats", 32'(acc_q.size()), 32'd4);
`ifndef AXIS_FRAME_GEN_LFSR_EN
    for (int k = 0; k < 4; k++) chk("t1_data", 32'(acc_q[k].d), 32'(8'h10 + k));
`endif
    chk("t1_last", 32'(acc_q[3].l), 32'd1);
    chk("t1_done", 32'(done_cnt), 32'd1);
    chk("t1_sent", 32'(frames_sent), 32'd1);

    // Two 3-beat frames with a 2-cycle gap.
    acc_q.delete(); done_cnt = 0;
    run_start(3, 2, 2, 8'h00);
    wait_idle(50); repeat (2) tick();
    chk("t2_beats", 32'(acc_q.size()), 32'd6);
`ifndef AXIS_FRAME_GEN_LFSR_EN
    for (int k = 0; k < 6; k++) chk("t2_data", 32'(acc_q[k].d), 32'(k % 3));
`endif
    chk("t2_done", 32'(done_cnt), 32'd1);
    chk("t2_sent", 32'(frames_sent), 32'd3);

    // Backpressure pattern 1,0,0 repeating on a 5-beat frame.
    acc_q.delete(); done_cnt = 0;
    run_start(5, 1, 0, 8'h20);
    for (int c = 0; c < 60 && busy; c++) begin
      tready = (c % 3 == 0);
      tick();
    end
    tready = 1'b1;
    wait_idle(50); repeat (2) tick();
    chk("t3_beats", 32'(acc_q.size()), 32'd5);
    nl = 0;
    for (int k = 0; k < acc_q.size(); k++) begin
`ifndef AXIS_FRAME_GEN_LFSR_EN
      chk("t3_data", 32'(acc_q[k].d), 32'(8'h20 + k));
`endif
      nl += int'(acc_q[k].l);
    end
    chk("t3_one_last", 32'(nl), 32'd1);
    chk("t3_sent", 32'(frames_sent), 32'd4);

    // Abort while beat 2 is stalled.
    run_start(8, 3, 1, 8'h00);
    tick(); tick();
    tready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
`ifndef AXIS_FRAME_GEN_LFSR_EN
    chk("t4_hold_data", 32'(tdata), 32'd2);
`endif
    chk("t4_hold_last", 32'(tlast), 32'd0);
    tick();
    tready = 1'b1;
    tick();
`ifndef AXIS_FRAME_GEN_LFSR_EN
    chk("t4_trunc_data", 32'(tdata), 32'd3);
`endif
    chk("t4_trunc_last", 32'(tlast), 32'd1);
    chk("t4_trunc_user", 32'(tuser), 32'd1);
    tick();
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_sent", 32'(frames_sent), 32'd5);
    tick();

    // Zero-length start is ignored; then reset mid-frame.
    run_start(0, 2, 0, 8'h05);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_valid", 32'(tvalid), 32'd0);
    tick();
    chk("t5_done", 32'(done), 32'd0);
    run_start(6, 2, 0, 8'h01);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("t5_rst_valid", 32'(tvalid), 32'd0);
    chk("t5_rst_last", 32'(tlast), 32'd0);
    chk("t5_rst_user", 32'(tuser), 32'd0);
    chk("t5_rst_data", 32'(tdata), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_sent", 32'(frames_sent), 32'd0);
    rst_n = 1'b1;
    tick();

`ifdef AXIS_FRAME_GEN_LFSR_EN
    acc_q.delete();
    run_start(4, 2, 0, 8'h01);
    wait_idle(50); repeat (2) tick();
    chk("lfsr_beats", 32'(acc_q.size()), 32'd8);
    for (int k = 0; k < 8; k++) chk("lfsr_data", 32'(acc_q[k].d), 32'(gold[k % 4]));
`endif

    // Random traffic: starts (some zero-sized, some while busy), aborts, backpressure.
    for (int c = 0; c < 4000; c++) begin
      tready      = ($urandom_range(0, 3) != 0);
      abort       = ($urandom_range(0, 59) == 0);
      start       = ($urandom_range(0, 9) == 0);
      frame_len   = 16'($urandom_range(0, 6));
      frame_count = 16'($urandom_range(0, 3));
      gap_len     = 8'($urandom_range(0, 3));
      seed        = 8'($urandom);
      tick();
    end
    start = 1'b0; abort = 1'b0; tready = 1'b1;
    wait_idle(200);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
